apb_io_bank: RTL and testbench
==============================

# apb_io_bank

Parametrised APB4 slave exposing `N_CH` identical GPIO channels, each with output, synchronised input, sticky rising-edge event and interrupt-enable registers. It is the multi-channel successor of the single fixed register block wrapped by the test `dut`, and adds configurable wait states, error responses and per-channel interrupts. It sits directly on the APB fabric, with its `gpio_*` and `irq` pins routed to the pad ring or the interrupt controller.

## Interface
- `REGWIDTH`, 32: data and register width; must be a multiple of 8.
- `G_ADDR_WIDTH`, 8: APB address width; must be ≥ clog2(`N_CH`·4·`REGWIDTH`/8).
- `N_CH`, 4: number of channels, 1..16.
- `WAIT_STATES`, 0: extra access-phase cycles before `s_apb_pready`, 0..15.
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst` in 1: asynchronous assert, active-low reset.
- `s_apb_psel`, `s_apb_penable`, `s_apb_pwrite` in 1: APB control.
- `s_apb_pprot` in 3: protection; bit0 = privileged.
- `s_apb_paddr` in `G_ADDR_WIDTH`: byte address.
- `s_apb_pwdata` in `REGWIDTH`: write data.
- `s_apb_pstrb` in `REGWIDTH/8`: byte strobes.
- `s_apb_pready` out 1: transfer complete.
- `s_apb_prdata` out `REGWIDTH`: read data.
- `s_apb_pslverr` out 1: error response.
- `gpio_in` in `N_CH*REGWIDTH`: asynchronous inputs; channel c occupies slice [c*REGWIDTH +: REGWIDTH].
- `gpio_out` out `N_CH*REGWIDTH`: OUT register contents.
- `irq` out `N_CH`: per-channel interrupt, level-high.

## Operation
- Word index = `paddr >> clog2(REGWIDTH/8)`. Low byte-offset bits are ignored. Channel = word[..:2]; register = word[1:0].
- Register 0, OUT (RW): byte-strobed write. Drives `gpio_out`.
- Register 1, IN (RO): 2-flop synchronised `gpio_in`. A write to IN returns `pslverr`=1 and has no effect.
- Register 2, EVENT (W1C): bit sets on a rising edge of the synchronised input. Writing 1 clears the bit, subject to `pstrb`.
- Register 3, IRQ_EN (RW, byte-strobed).
- `irq[c]` = |(EVENT & IRQ_EN), from registers (no combinational path from the APB inputs).
- Channel ≥ `N_CH`: reads return 0 with `pslverr`=1; writes are ignored with `pslverr`=1.
- Write with `pprot[0]`=0 to any register: ignored, `pslverr`=1. Reads are never protection-checked.
- Simultaneous W1C and a new edge on the same bit: the set wins (bit stays 1).
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE → SETUP on `psel`&!`penable`.
  - SETUP → ACCESS unconditionally; the wait counter loads 0.
  - ACCESS holds while counter < `WAIT_STATES`, incrementing each cycle.
  - ACCESS → IDLE on completion, or → SETUP if `psel`&!`penable` is already presented.
  - A protocol violation (`psel` dropped during ACCESS) returns to IDLE with no register update.

## Timing
- Reset values: every output is 0, as are all registers, synchronisers, the edge-detect flop, the counter, and the FSM (IDLE).
- Reset asserted mid-transfer aborts the transfer. No partial write is retained.
- `pready` = ACCESS & (counter == `WAIT_STATES`). With 0 wait states, `pready` is high in the first access cycle.
- `prdata` and `pslverr` are valid only while `pready`=1, and are 0 otherwise.
- A write commits on the rising edge at which `psel`&`penable`&`pready`. `gpio_out` and `irq` reflect it in the next cycle.
- An input toggle reaches IN after 2 edges. The EVENT bit sets on the 3rd edge, and `irq` rises in the same cycle as the EVENT bit.
- Minimum transfer length is 2 + `WAIT_STATES` cycles. Back-to-back transfers add no idle cycle.

## Structure
- Package `apb_io_bank_pkg` holds:
  - the `reg_sel_e` enum (OUT, IN, EVENT, IRQ_EN);
  - the `apb_state_e` enum (IDLE, SETUP, ACCESS);
  - the register word-offset constants.
- Sub-module `apb_io_bank_ch` holds the per-channel OUT, IN sync, EVENT and IRQ_EN registers plus the irq term. It is instantiated `N_CH` times by generate.
- The top level holds the FSM, the wait counter, address decode, the error logic and the read mux.

## Test plan
- Reset, then idle: all outputs 0. Write 0xA5A5_0F0F to ch2 OUT with `pstrb`=0b0011 and `pprot`=1 → `gpio_out` ch2 = 0x0000_0F0F; readback matches, `pslverr`=0.
- `WAIT_STATES`=3: a read of ch0 IN → `pready` high exactly 4 access cycles after SETUP; `prdata` equals `gpio_in` driven ≥2 cycles earlier.
- Raise `gpio_in` ch1 bit 5 with IRQ_EN bit 5 = 1 → EVENT = 0x20 and `irq[1]`=1 on the 3rd edge. W1C 0x20 → `irq[1]`=0 next cycle. W1C in the same cycle as a new edge → bit remains 1.
- Access ch = `N_CH` → read `prdata`=0, `pslverr`=1. A write to IN, or a write with `pprot[0]`=0 → `pslverr`=1, register unchanged.
- Back-to-back write then read to the same OUT → the read returns the new value with no idle cycle. Assert `rst` during ACCESS → the pending write is discarded and all outputs return to 0.

Source files
------------

// File: rtl/apb_io_bank_pkg.sv
// Shared types and constants for the APB GPIO bank: register selectors,
// transfer-phase encoding and the wait-counter width.
package apb_io_bank_pkg;

  localparam logic [1:0] OFF_OUT    = 2'd0;
  localparam logic [1:0] OFF_IN     = 2'd1;
  localparam logic [1:0] OFF_EVENT  = 2'd2;
  localparam logic [1:0] OFF_IRQ_EN = 2'd3;

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    REG_OUT    = OFF_OUT,
    REG_IN     = OFF_IN,
    REG_EVENT  = OFF_EVENT,
    REG_IRQ_EN = OFF_IRQ_EN
  } reg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/apb_io_bank_ch.sv
// One GPIO channel: OUT, 2-flop input synchroniser, sticky rising-edge EVENT,
// IRQ_EN and the registered interrupt term.
module apb_io_bank_ch #(
  parameter int unsigned REGWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REGWIDTH-1:0]   gpio_i,
  input  logic [REGWIDTH-1:0]   wdata_i,
  input  logic [REGWIDTH/8-1:0] wstrb_i,
  input  logic                  wr_out_i,
  input  logic                  wr_evt_i,
  input  logic                  wr_ien_i,
  output logic [REGWIDTH-1:0]   out_o,
  output logic [REGWIDTH-1:0]   in_o,
  output logic [REGWIDTH-1:0]   evt_o,
  output logic [REGWIDTH-1:0]   ien_o,
  output logic                  irq_o
);

  logic [REGWIDTH-1:0] sync1_q, sync2_q, prev_q;
  logic [REGWIDTH-1:0] out_q, out_d, ien_q, ien_d, evt_q, evt_d;
  logic [REGWIDTH-1:0] mask_c, clr_c;
  logic                irq_q, irq_d;

  always_comb begin
    for (int i = 0; i < int'(REGWIDTH); i++) mask_c[i] = wstrb_i[i/8];
  end

  // A new edge is OR-ed in after the clear, so set wins over W1C.
  always_comb begin
    out_d = out_q;
    ien_d = ien_q;
    clr_c = '0;
    if (wr_out_i) out_d = (out_q & ~mask_c) | (wdata_i & mask_c);
    if (wr_ien_i) ien_d = (ien_q & ~mask_c) | (wdata_i & mask_c);
    if (wr_evt_i) clr_c = wdata_i & mask_c;
    evt_d = (evt_q & ~clr_c) | (sync2_q & ~prev_q);
    irq_d = |(evt_d & ien_d);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      out_q   <= '0;
      ien_q   <= '0;
      evt_q   <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync1_q <= gpio_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      out_q   <= out_d;
      ien_q   <= ien_d;
      evt_q   <= evt_d;
      irq_q   <= irq_d;
    end
  end

  assign out_o = out_q;
  assign in_o  = sync2_q;
  assign evt_o = evt_q;
  assign ien_o = ien_q;
  assign irq_o = irq_q;

endmodule

// File: rtl/apb_io_bank.sv
// APB4 slave fronting N_CH GPIO channels: transfer FSM with wait counter,
// address decode, error response and read mux.
module apb_io_bank
  import apb_io_bank_pkg::*;
#(
  parameter int unsigned REGWIDTH     = 32,
  parameter int unsigned G_ADDR_WIDTH = 8,
  parameter int unsigned N_CH         = 4,
  parameter int unsigned WAIT_STATES  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       s_apb_psel,
  input  logic                       s_apb_penable,
  input  logic                       s_apb_pwrite,
  input  logic [2:0]                 s_apb_pprot,
  input  logic [G_ADDR_WIDTH-1:0]    s_apb_paddr,
  input  logic [REGWIDTH-1:0]        s_apb_pwdata,
  input  logic [REGWIDTH/8-1:0]      s_apb_pstrb,
  output logic                       s_apb_pready,
  output logic [REGWIDTH-1:0]        s_apb_prdata,
  output logic                       s_apb_pslverr,
  input  logic [N_CH*REGWIDTH-1:0]   gpio_in,
  output logic [N_CH*REGWIDTH-1:0]   gpio_out,
  output logic [N_CH-1:0]            irq
);

  localparam int unsigned OFFS_W = $clog2(REGWIDTH/8);

  apb_state_e              state_q, state_d, cur_c;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [G_ADDR_WIDTH-1:0] word_c, ch_c;
  reg_sel_e                reg_c;
  logic                    ch_ok_c, err_c, pready_c, commit_c;
  logic [REGWIDTH-1:0]     rdata_c;
  logic [REGWIDTH-1:0]     out_a [N_CH];
  logic [REGWIDTH-1:0]     in_a  [N_CH];
  logic [REGWIDTH-1:0]     evt_a [N_CH];
  logic [REGWIDTH-1:0]     ien_a [N_CH];
  logic [1:0]              unused_prot_c;

  assign unused_prot_c = s_apb_pprot[2:1];

  assign word_c   = s_apb_paddr >> OFFS_W;
  assign ch_c     = word_c >> 2;
  assign reg_c    = reg_sel_e'(word_c[1:0]);
  assign ch_ok_c  = ch_c < G_ADDR_WIDTH'(N_CH);
  assign err_c    = !ch_ok_c ||
                    (s_apb_pwrite && ((reg_c == REG_IN) || !s_apb_pprot[0]));

  // A setup phase on the bus is recognised in the cycle it is presented.
  assign cur_c    = (s_apb_psel && !s_apb_penable) ? ST_SETUP : state_q;
  assign pready_c = (cur_c == ST_ACCESS) && (cnt_q == CNT_W'(WAIT_STATES));
  assign commit_c = s_apb_psel && s_apb_penable && pready_c && s_apb_pwrite && !err_c;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (cur_c)
      ST_SETUP: begin
        state_d = ST_ACCESS;
        cnt_d   = '0;
      end
      ST_ACCESS: begin
        if (!s_apb_psel) state_d = ST_IDLE;
        else if (cnt_q < CNT_W'(WAIT_STATES)) cnt_d = cnt_q + CNT_W'(1);
        else state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    rdata_c = '0;
    for (int c = 0; c < int'(N_CH); c++) begin
      if (ch_c == G_ADDR_WIDTH'(c)) begin
        unique case (reg_c)
          REG_OUT:   rdata_c = out_a[c];
          REG_IN:    rdata_c = in_a[c];
          REG_EVENT: rdata_c = evt_a[c];
          default:   rdata_c = ien_a[c];
        endcase
      end
    end
  end

  assign s_apb_pready  = pready_c;
  assign s_apb_prdata  = (pready_c && !s_apb_pwrite) ? rdata_c : '0;
  assign s_apb_pslverr = pready_c && err_c;

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    logic sel_c;
    assign sel_c = commit_c && (ch_c == G_ADDR_WIDTH'(c));

    apb_io_bank_ch #(.REGWIDTH(REGWIDTH)) u_ch (
      .clk      (clk),
      .rst      (rst),
      .gpio_i   (gpio_in[c*REGWIDTH +: REGWIDTH]),
      .wdata_i  (s_apb_pwdata),
      .wstrb_i  (s_apb_pstrb),
      .wr_out_i (sel_c && (reg_c == REG_OUT)),
      .wr_evt_i (sel_c && (reg_c == REG_EVENT)),
      .wr_ien_i (sel_c && (reg_c == REG_IRQ_EN)),
      .out_o    (out_a[c]),
      .in_o     (in_a[c]),
      .evt_o    (evt_a[c]),
      .ien_o    (ien_a[c]),
      .irq_o    (irq[c])
    );

    assign gpio_out[c*REGWIDTH +: REGWIDTH] = out_a[c];
  end

endmodule

// File: tb/tb_apb_io_bank.sv
// Bench for apb_io_bank: directed scenarios plus random APB traffic against
// an array-based register model of the bank.
module tb_apb_io_bank;

  localparam int unsigned RW = 32;
  localparam int unsigned AW = 8;
  localparam int unsigned NC = 4;
  localparam int unsigned WS = 3;
  localparam int unsigned BW = NC*RW;

  logic          clk = 1'b0;
  logic          rst;
  logic          psel, penable, pwrite;
  logic [2:0]    pprot;
  logic [AW-1:0] paddr;
  logic [RW-1:0] pwdata;
  logic [3:0]    pstrb;
  logic          pready, pslverr;
  logic [RW-1:0] prdata;
  logic [BW-1:0] gpio_in, gpio_out;
  logic [NC-1:0] irq;

  apb_io_bank #(
    .REGWIDTH(RW), .G_ADDR_WIDTH(AW), .N_CH(NC), .WAIT_STATES(WS)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .s_apb_psel    (psel),
    .s_apb_penable (penable),
    .s_apb_pwrite  (pwrite),
    .s_apb_pprot   (pprot),
    .s_apb_paddr   (paddr),
    .s_apb_pwdata  (pwdata),
    .s_apb_pstrb   (pstrb),
    .s_apb_pready  (pready),
    .s_apb_prdata  (prdata),
    .s_apb_pslverr (pslverr),
    .gpio_in       (gpio_in),
    .gpio_out      (gpio_out),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_pass = 0;
  logic [RW-1:0] m_out [NC];
  logic [RW-1:0] m_ien [NC];
  logic [RW-1:0] m_evt [NC];
  logic [BW-1:0] m_gpio;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_chk++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  function automatic logic [RW-1:0] smask(input logic [3:0] s);
    logic [RW-1:0] m;
    for (int i = 0; i < 4; i++) m[i*8 +: 8] = s[i] ? 8'hFF : 8'h00;
    return m;
  endfunction

  task automatic apb_idle();
    @(posedge clk); #1;
    psel = 1'b0;
    penable = 1'b0;
  endtask

  // Runs setup + access; returns in the completing cycle with psel still high.
  task automatic xfer(input logic wr, input logic [AW-1:0] addr, input logic [RW-1:0] wd,
                      input logic [3:0] strb, input logic [2:0] prot,
                      output logic [RW-1:0] rd, output logic err);
    int n;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr;
    pwdata = wd; pstrb = strb; pprot = prot;
    @(posedge clk); #1;
    penable = 1'b1;
    #1;
    n = 1;
    while (!pready && n < 40) begin
      @(posedge clk); #2;
      n++;
    end
    check("pready_seen", BW'(pready), BW'(1));
    check("access_cycles", BW'(n), BW'(WS + 1));
    rd  = prdata;
    err = pslverr;
  endtask

  task automatic do_op(input logic wr, input int ch, input int r, input logic [RW-1:0] wd,
                       input logic [3:0] strb, input logic [2:0] prot);
    logic [RW-1:0] rd, exp_rd, m;
    logic          err, exp_err;
    xfer(wr, AW'(ch*16 + r*4), wd, strb, prot, rd, err);
    m = smask(strb);
    exp_rd = '0;
    if (ch >= int'(NC)) exp_err = 1'b1;
    else if (wr) begin
      exp_err = (r == 1) || !prot[0];
      if (!exp_err) begin
        case (r)
          0:       m_out[ch] = (m_out[ch] & ~m) | (wd & m);
          2:       m_evt[ch] = m_evt[ch] & ~(wd & m);
          default: m_ien[ch] = (m_ien[ch] & ~m) | (wd & m);
        endcase
      end
    end else begin
      exp_err = 1'b0;
      case (r)
        0:       exp_rd = m_out[ch];
        1:       exp_rd = m_gpio[ch*RW +: RW];
        2:       exp_rd = m_evt[ch];
        default: exp_rd = m_ien[ch];
      endcase
    end
    check("pslverr", BW'(err), BW'(exp_err));
    if (!wr) check("prdata", BW'(rd), BW'(exp_rd));
  endtask

  task automatic check_pins();
    logic [BW-1:0] eo;
    logic [NC-1:0] ei;
    for (int c = 0; c < int'(NC); c++) begin
      eo[c*RW +: RW] = m_out[c];
      ei[c] = |(m_evt[c] & m_ien[c]);
    end
    check("gpio_out", gpio_out, eo);
    check("irq", BW'(irq), BW'(ei));
  endtask

  task automatic set_gpio(input logic [BW-1:0] nv);
    apb_idle();
    gpio_in = nv;
    for (int c = 0; c < int'(NC); c++)
      m_evt[c] = m_evt[c] | (nv[c*RW +: RW] & ~m_gpio[c*RW +: RW]);
    m_gpio = nv;
    repeat (4) apb_idle();
  endtask

  task automatic model_reset();
    for (int c = 0; c < int'(NC); c++) begin
      m_out[c] = '0; m_ien[c] = '0; m_evt[c] = '0;
    end
  endtask

  initial begin
    rst = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; pprot = '0;
    paddr = '0; pwdata = '0; pstrb = '0; gpio_in = '0; m_gpio = '0;
    model_reset();

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpio_out", gpio_out, '0);
    check("rst_irq", BW'(irq), '0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("idle_pready", BW'(pready), '0);
    check("idle_prdata", BW'(prdata), '0);
    check("idle_pslverr", BW'(pslverr), '0);
    check("idle_gpio_out", gpio_out, '0);

    // Byte-strobed OUT write and readback
    do_op(1'b1, 2, 0, 32'hA5A5_0F0F, 4'b0011, 3'b001);
    apb_idle();
    check("ch2_out_pins", BW'(gpio_out[95:64]), BW'(32'h0000_0F0F));
    check_pins();
    do_op(1'b0, 2, 0, '0, 4'h0, 3'b001);
    apb_idle();

    // Synchronised IN read with wait states
    set_gpio({$urandom, $urandom, $urandom, $urandom});
    do_op(1'b0, 0, 1, '0, 4'h0, 3'b000);
    apb_idle();

    // Edge event, irq timing and W1C
    set_gpio(m_gpio & ~(BW'(1) << 37));
    do_op(1'b1, 1, 2, 32'hFFFF_FFFF, 4'hF, 3'b001);
    do_op(1'b1, 1, 3, 32'h0000_0020, 4'hF, 3'b001);
    apb_idle();
    check("irq1_before_edge", BW'(irq[1]), '0);
    @(posedge clk); #1;
    gpio_in[37] = 1'b1;
    m_gpio[37] = 1'b1;
    @(posedge clk); #1;
    check("irq1_edge1", BW'(irq[1]), '0);
    @(posedge clk); #1;
    check("irq1_edge2", BW'(irq[1]), '0);
    @(posedge clk); #1;
    check("irq1_edge3", BW'(irq[1]), BW'(1));
    m_evt[1] = m_evt[1] | 32'h20;
    do_op(1'b0, 1, 2, '0, 4'h0, 3'b001);
    do_op(1'b1, 1, 2, 32'h0000_0020, 4'h1, 3'b001);
    apb_idle();
    check("irq1_after_w1c", BW'(irq[1]), '0);
    check_pins();

    // W1C landing on the same edge as a new rising input: set wins
    set_gpio(m_gpio & ~(BW'(1) << 37));
    fork
      do_op(1'b1, 1, 2, 32'h0000_0020, 4'h1, 3'b001);
      begin
        repeat (3) @(posedge clk);
        #2;
        gpio_in[37] = 1'b1;
      end
    join
    m_evt[1] = m_evt[1] | 32'h20;
    m_gpio[37] = 1'b1;
    apb_idle();
    check("irq1_race", BW'(irq[1]), BW'(1));
    do_op(1'b0, 1, 2, '0, 4'h0, 3'b001);
    apb_idle();

    // Error responses
    do_op(1'b0, int'(NC), 0, '0, 4'h0, 3'b001);
    do_op(1'b1, int'(NC), 0, 32'hFFFF_FFFF, 4'hF, 3'b001);
    do_op(1'b1, 0, 1, 32'h1234_5678, 4'hF, 3'b001);
    do_op(1'b0, 0, 1, '0, 4'h0, 3'b001);
    do_op(1'b1, 3, 0, 32'hDEAD_BEEF, 4'hF, 3'b000);
    apb_idle();
    check_pins();

    // Back-to-back write then read, no idle cycle between
    do_op(1'b1, 0, 0, 32'h1234_5678, 4'hF, 3'b001);
    do_op(1'b0, 0, 0, '0, 4'h0, 3'b001);
    apb_idle();

    // Random traffic
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 4) == 0) set_gpio({$urandom, $urandom, $urandom, $urandom});
      do_op(1'($urandom_range(0, 1)), $urandom_range(0, NC), $urandom_range(0, 3),
            $urandom, 4'($urandom), {2'($urandom), ($urandom_range(0, 3) != 0)});
      if ($urandom_range(0, 2) == 0) begin
        apb_idle();
        check_pins();
      end
    end
    apb_idle();
    check_pins();

    // Reset asserted during ACCESS discards the pending write
    set_gpio('0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = AW'(3*16);
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; pprot = 3'b001;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("mid_rst_pready", BW'(pready), '0);
    check("mid_rst_prdata", BW'(prdata), '0);
    check("mid_rst_pslverr", BW'(pslverr), '0);
    check("mid_rst_gpio_out", gpio_out, '0);
    check("mid_rst_irq", BW'(irq), '0);
    psel = 1'b0;
    penable = 1'b0;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) apb_idle();
    check_pins();
    do_op(1'b0, 3, 0, '0, 4'h0, 3'b001);
    apb_idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
